// File: rtl/nfc_pkg.sv
// rtl/nfc_pkg.sv - shared state type, keep constants and keep-mask helper for the read stream packer
package nfc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        FLUSH   = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } nfcState_t;

    localparam logic [1:0] KEEP_FULL16 = 2'b11;
    localparam logic [1:0] KEEP_LOW16  = 2'b01;

    function automatic logic [3:0] keep_from_bytes(input logic [2:0] n);
        case (n)
            3'd0:    keep_from_bytes = 4'b0000;
            3'd1:    keep_from_bytes = 4'b0001;
            3'd2:    keep_from_bytes = 4'b0011;
            3'd3:    keep_from_bytes = 4'b0111;
            default: keep_from_bytes = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/nfc_stream_out_reg.sv
// rtl/nfc_stream_out_reg.sv - 32-bit output word register; contents hold while valid is stalled
module nfc_stream_out_reg (
    input  logic        iSystemClock,
    input  logic        iModuleReset_n,
    input  logic        iLoad,
    input  logic [31:0] iData,
    input  logic [3:0]  iKeep,
    input  logic        iLast,
    input  logic        iReady,
    output logic        oValid,
    output logic [31:0] oData,
    output logic [3:0]  oKeep,
    output logic        oLast
);

    // The caller only loads when the register is empty or being drained this cycle.
    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            oValid <= 1'b0;
            oData  <= '0;
            oKeep  <= '0;
            oLast  <= 1'b0;
        end else if (iLoad) begin
            oValid <= 1'b1;
            oData  <= iData;
            oKeep  <= iKeep;
            oLast  <= iLast;
        end else if (iReady) begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: rtl/nfc_read_stream_packer.sv
// rtl/nfc_read_stream_packer.sv - packs 16-bit NAND read beats into 32-bit words and checks transfer length
// Define NFC_PACKER_CHECKSUM_EN to add oChecksum, the XOR of all accepted output words.
module nfc_read_stream_packer
    import nfc_pkg::*;
#(
    parameter int MAX_LEN_W = 16
) (
    input  logic                 iSystemClock,
    input  logic                 iModuleReset_n,
    input  logic                 iStart,
    input  logic [MAX_LEN_W-1:0] iByteCount,
    input  logic                 iPI_Buff_Valid,
    input  logic [15:0]          iPI_Buff_Data,
    input  logic [1:0]           iPI_Buff_Keep,
    input  logic                 iPI_Buff_Last,
    output logic                 oPI_Buff_Ready,
    output logic                 oM_Valid,
    output logic [31:0]          oM_Data,
    output logic [3:0]           oM_Keep,
    output logic                 oM_Last,
    input  logic                 iM_Ready,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oLengthError,
    output logic [MAX_LEN_W-1:0] oRecvBytes
`ifdef NFC_PACKER_CHECKSUM_EN
    ,
    output logic [31:0]          oChecksum
`endif
);

    nfcState_t            state;
    logic [MAX_LEN_W-1:0] expLen;
    logic [MAX_LEN_W-1:0] recvBytes;
    logic [15:0]          holdData;
    logic                 holdFull;
    logic                 lengthError;

    logic                 inCollect;
    logic                 beatAccept;
    logic [1:0]           beatPop;
    logic [MAX_LEN_W:0]   countSum;
    logic [MAX_LEN_W-1:0] nextRecv;
    logic                 reachLen;
    logic                 terminate;
    logic                 strayLow;
    logic                 lengthMiss;
    logic [2:0]           effBytes;
    logic [2:0]           wordBytes;
    logic                 emitWord;
    logic [31:0]          wordRaw;
    logic [3:0]           wordKeep;
    logic [31:0]          wordData;

    assign inCollect      = (state == COLLECT);
    assign oPI_Buff_Ready = (inCollect && (!oM_Valid || iM_Ready)) || (state == DRAIN);
    assign beatAccept     = iPI_Buff_Valid && oPI_Buff_Ready;

    assign beatPop  = {1'b0, iPI_Buff_Keep[0]} + {1'b0, iPI_Buff_Keep[1]};
    assign countSum = {1'b0, recvBytes} + {{(MAX_LEN_W-1){1'b0}}, beatPop};
    assign nextRecv = countSum[MAX_LEN_W] ? {MAX_LEN_W{1'b1}} : countSum[MAX_LEN_W-1:0];

    assign reachLen  = (nextRecv >= expLen);
    assign terminate = iPI_Buff_Last || reachLen;
    // A lone low byte mid-stream is flagged and then packed as a full half-word.
    assign strayLow  = (iPI_Buff_Keep == KEEP_LOW16) && !terminate;
    assign lengthMiss = strayLow
                      || (iPI_Buff_Last && (nextRecv != expLen))
                      || (reachLen && !iPI_Buff_Last);

    assign effBytes  = ((iPI_Buff_Keep == KEEP_FULL16) || strayLow) ? 3'd2 : {1'b0, beatPop};
    assign wordBytes = (holdFull ? 3'd2 : 3'd0) + effBytes;
    assign emitWord  = beatAccept && inCollect
                     && ((wordBytes == 3'd4) || (terminate && (wordBytes != 3'd0)));

    assign wordRaw  = holdFull ? {iPI_Buff_Data, holdData} : {16'd0, iPI_Buff_Data};
    assign wordKeep = keep_from_bytes(wordBytes);
    assign wordData = wordRaw & {{8{wordKeep[3]}}, {8{wordKeep[2]}}, {8{wordKeep[1]}}, {8{wordKeep[0]}}};

    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n) begin
            state       <= IDLE;
            expLen      <= '0;
            recvBytes   <= '0;
            holdData    <= '0;
            holdFull    <= 1'b0;
            lengthError <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state       <= COLLECT;
                        expLen      <= iByteCount;
                        recvBytes   <= '0;
                        lengthError <= 1'b0;
                        holdFull    <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (beatAccept) begin
                        recvBytes <= nextRecv;
                        if (lengthMiss)
                            lengthError <= 1'b1;
                        if (emitWord) begin
                            holdFull <= 1'b0;
                        end else if (effBytes == 3'd2) begin
                            holdData <= iPI_Buff_Data;
                            holdFull <= 1'b1;
                        end
                        // With nothing left to emit there is no Last word to wait for.
                        if (terminate)
                            state <= !iPI_Buff_Last ? DRAIN : (emitWord ? FLUSH : DONE);
                    end
                end
                FLUSH: begin
                    if (oM_Valid && oM_Last && iM_Ready)
                        state <= DONE;
                end
                DRAIN: begin
                    if (beatAccept) begin
                        recvBytes <= nextRecv;
                        if (iPI_Buff_Last)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    nfc_stream_out_reg uOutReg (
        .iSystemClock   (iSystemClock),
        .iModuleReset_n (iModuleReset_n),
        .iLoad          (emitWord),
        .iData          (wordData),
        .iKeep          (wordKeep),
        .iLast          (terminate),
        .iReady         (iM_Ready),
        .oValid         (oM_Valid),
        .oData          (oM_Data),
        .oKeep          (oM_Keep),
        .oLast          (oM_Last)
    );

    assign oBusy        = (state != IDLE);
    assign oDone        = (state == DONE);
    assign oLengthError = lengthError;
    assign oRecvBytes   = recvBytes;

`ifdef NFC_PACKER_CHECKSUM_EN
    logic [31:0] checksum;

    // Words are already byte-masked at load, so the raw data can be folded in.
    always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
        if (!iModuleReset_n)
            checksum <= '0;
        else if ((state == IDLE) && iStart)
            checksum <= '0;
        else if (oM_Valid && iM_Ready)
            checksum <= checksum ^ oM_Data;
    end

    assign oChecksum = checksum;
`endif

endmodule

// File: tb/tb_nfc_read_stream_packer.sv
// tb/tb_nfc_read_stream_packer.sv - directed and randomized checks of nfc_read_stream_packer against a byte-stream model
module tb_nfc_read_stream_packer;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic [15:0] byteCount = '0;
    logic        inValid = 1'b0;
    logic [15:0] inData = '0;
    logic [1:0]  inKeep = '0;
    logic        inLast = 1'b0;
    logic        mReady = 1'b1;
    logic        inReady;
    logic        mValid;
    logic [31:0] mData;
    logic [3:0]  mKeep;
    logic        mLast;
    logic        busy;
    logic        done;
    logic        lenErr;
    logic [15:0] recvBytes;
`ifdef NFC_PACKER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int nChecks = 0;
    int nFail = 0;
    int readyMode = 1;
    int gapMode = 0;
    int doneCount = 0;

    logic [15:0] bData[$];
    logic [1:0]  bKeep[$];
    logic        bLast[$];
    logic [31:0] gotData[$];
    logic [3:0]  gotKeep[$];
    logic        gotLast[$];
    logic [31:0] expData[$];
    logic [3:0]  expKeep[$];
    logic        expLast[$];
    logic        expErr;
    int          expRecv;

    nfc_read_stream_packer dut (
        .iSystemClock   (clk),
        .iModuleReset_n (rstN),
        .iStart         (start),
        .iByteCount     (byteCount),
        .iPI_Buff_Valid (inValid),
        .iPI_Buff_Data  (inData),
        .iPI_Buff_Keep  (inKeep),
        .iPI_Buff_Last  (inLast),
        .oPI_Buff_Ready (inReady),
        .oM_Valid       (mValid),
        .oM_Data        (mData),
        .oM_Keep        (mKeep),
        .oM_Last        (mLast),
        .iM_Ready       (mReady),
        .oBusy          (busy),
        .oDone          (done),
        .oLengthError   (lenErr),
        .oRecvBytes     (recvBytes)
`ifdef NFC_PACKER_CHECKSUM_EN
        ,
        .oChecksum      (checksum)
`endif
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        mReady = (readyMode == 0) ? 1'b0 : (readyMode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end

    // Handshakes seen at a falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (rstN) begin
            if (mValid && mReady) begin
                gotData.push_back(mData);
                gotKeep.push_back(mKeep);
                gotLast.push_back(mLast);
            end
            if (done)
                doneCount++;
        end
    end

    task automatic build_model(input int expLen);
        logic [7:0] bytesQ[$];
        int cnt;
        bit term;
        cnt = 0;
        term = 0;
        expErr = 1'b0;
        foreach (bData[i]) begin
            bit ends;
            cnt = cnt + int'(bKeep[i][0]) + int'(bKeep[i][1]);
            if (cnt > 65535) cnt = 65535;
            ends = bLast[i] || (cnt >= expLen);
            if (!term) begin
                if (bKeep[i] == 2'b11) begin
                    bytesQ.push_back(bData[i][7:0]);
                    bytesQ.push_back(bData[i][15:8]);
                end else if (bKeep[i] == 2'b01) begin
                    bytesQ.push_back(bData[i][7:0]);
                    if (!ends) begin
                        expErr = 1'b1;
                        bytesQ.push_back(bData[i][15:8]);
                    end
                end
                if (ends) begin
                    term = 1;
                    if (!bLast[i] || cnt != expLen) expErr = 1'b1;
                end
            end
        end
        expRecv = cnt;
        expData.delete();
        expKeep.delete();
        expLast.delete();
        for (int w = 0; w * 4 < bytesQ.size(); w++) begin
            logic [31:0] d;
            int n;
            d = '0;
            n = 0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < bytesQ.size()) begin
                    d[8*k +: 8] = bytesQ[w*4+k];
                    n++;
                end
            end
            expData.push_back(d);
            expKeep.push_back(4'((1 << n) - 1));
            expLast.push_back(w * 4 + 4 >= bytesQ.size());
        end
    endtask

    task automatic run_xfer(input int expLen);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        gotData.delete();
        gotKeep.delete();
        gotLast.delete();
        doneCount = 0;
        @(posedge clk); #1;
        start = 1'b1;
        byteCount = 16'(expLen);
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < bData.size() && cyc < 3000) begin
            inValid = (gapMode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            inData = bData[idx];
            inKeep = bKeep[idx];
            inLast = bLast[idx];
            @(negedge clk);
            if (inValid && inReady) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        inValid = 1'b0;
        inLast = 1'b0;
        cyc = 0;
        while ((doneCount == 0 || mValid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (idx < bData.size() || cyc >= 3000) begin
            nChecks++;
            nFail++;
            $display("FAIL xfer_timeout beats_sent %0d of %0d, done seen %0d", idx, bData.size(), doneCount);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        nChecks++;
        if ({inReady, mValid, mData, mKeep, mLast, busy, done, lenErr, recvBytes} !== 58'd0) begin
            nFail++;
            $display("FAIL reset_outputs got %h want 0", {inReady, mValid, mData, mKeep, mLast, busy, done, lenErr, recvBytes});
        end
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    task automatic test_basic;
        bData = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        bKeep = '{2'b11, 2'b11, 2'b11, 2'b11};
        bLast = '{1'b0, 1'b0, 1'b0, 1'b1};
        expData = '{32'h03020100, 32'h07060504};
        expKeep = '{4'b1111, 4'b1111};
        expLast = '{1'b0, 1'b1};
        run_xfer(8);
        nChecks++;
        if (gotData.size() != expData.size()) begin
            nFail++;
            $display("FAIL basic_words got %0d want %0d", gotData.size(), expData.size());
        end else begin
            foreach (expData[i]) begin
                nChecks++;
                if ({gotData[i], gotKeep[i], gotLast[i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                    nFail++;
                    $display("FAIL basic_word%0d got %h/%b/%b want %h/%b/%b", i, gotData[i], gotKeep[i], gotLast[i], expData[i], expKeep[i], expLast[i]);
                end
            end
        end
        nChecks++;
        if ({lenErr, recvBytes} !== {1'b0, 16'd8} || doneCount != 1) begin
            nFail++;
            $display("FAIL basic_status got err %b recv %0d done %0d want err 0 recv 8 done 1", lenErr, recvBytes, doneCount);
        end
    endtask

    task automatic test_partial;
        bData = '{16'h1100, 16'h3322, 16'h0044};
        bKeep = '{2'b11, 2'b11, 2'b01};
        bLast = '{1'b0, 1'b0, 1'b1};
        expData = '{32'h33221100, 32'h00000044};
        expKeep = '{4'b1111, 4'b0001};
        expLast = '{1'b0, 1'b1};
        run_xfer(5);
        nChecks++;
        if (gotData.size() != expData.size()) begin
            nFail++;
            $display("FAIL partial_words got %0d want %0d", gotData.size(), expData.size());
        end else begin
            foreach (expData[i]) begin
                nChecks++;
                if ({gotData[i], gotKeep[i], gotLast[i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                    nFail++;
                    $display("FAIL partial_word%0d got %h/%b/%b want %h/%b/%b", i, gotData[i], gotKeep[i], gotLast[i], expData[i], expKeep[i], expLast[i]);
                end
            end
        end
        nChecks++;
        if ({lenErr, recvBytes} !== {1'b0, 16'd5} || doneCount != 1) begin
            nFail++;
            $display("FAIL partial_status got err %b recv %0d done %0d want err 0 recv 5 done 1", lenErr, recvBytes, doneCount);
        end
    endtask

    task automatic test_overlength;
        bData = '{16'h0100, 16'h0302, 16'h0504};
        bKeep = '{2'b11, 2'b11, 2'b11};
        bLast = '{1'b0, 1'b0, 1'b1};
        run_xfer(4);
        nChecks++;
        if (gotData.size() != 1) begin
            nFail++;
            $display("FAIL overlen_words got %0d want 1", gotData.size());
        end else if ({gotData[0], gotKeep[0], gotLast[0]} !== {32'h03020100, 4'b1111, 1'b1}) begin
            nFail++;
            $display("FAIL overlen_word got %h/%b/%b want 03020100/1111/1", gotData[0], gotKeep[0], gotLast[0]);
        end
        nChecks++;
        if ({lenErr, recvBytes} !== {1'b1, 16'd6} || doneCount != 1) begin
            nFail++;
            $display("FAIL overlen_status got err %b recv %0d done %0d want err 1 recv 6 done 1", lenErr, recvBytes, doneCount);
        end
    endtask

    task automatic test_backpressure;
        bData = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        bKeep = '{2'b11, 2'b11, 2'b11, 2'b11};
        bLast = '{1'b0, 1'b0, 1'b0, 1'b1};
        readyMode = 0;
        fork
            run_xfer(8);
            begin
                int cyc;
                cyc = 0;
                while (!mValid && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                end
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    nChecks++;
                    if ({mValid, inReady, mData, mKeep, mLast} !== {1'b1, 1'b0, 32'h03020100, 4'b1111, 1'b0}) begin
                        nFail++;
                        $display("FAIL stall_hold cycle %0d got v%b rdy%b %h/%b/%b want v1 rdy0 03020100/1111/0", c, mValid, inReady, mData, mKeep, mLast);
                    end
                end
                readyMode = 1;
            end
        join
        nChecks++;
        if (gotData.size() != 2) begin
            nFail++;
            $display("FAIL stall_words got %0d want 2", gotData.size());
        end else if ({gotData[0], gotData[1], gotLast[0], gotLast[1]} !== {32'h03020100, 32'h07060504, 1'b0, 1'b1}) begin
            nFail++;
            $display("FAIL stall_data got %h %h last %b%b want 03020100 07060504 last 01", gotData[0], gotData[1], gotLast[0], gotLast[1]);
        end
    endtask

    task automatic test_start_busy_and_reset;
        bData = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        bKeep = '{2'b11, 2'b11, 2'b11, 2'b11};
        bLast = '{1'b0, 1'b0, 1'b0, 1'b1};
        fork
            run_xfer(8);
            begin
                repeat (4) @(posedge clk);
                #1;
                start = 1'b1;
                byteCount = 16'd2;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        nChecks++;
        if (gotData.size() != 2 || lenErr !== 1'b0 || recvBytes !== 16'd8 || doneCount != 1) begin
            nFail++;
            $display("FAIL busy_start got words %0d err %b recv %0d done %0d want words 2 err 0 recv 8 done 1", gotData.size(), lenErr, recvBytes, doneCount);
        end
        readyMode = 0;
        @(posedge clk); #1;
        start = 1'b1;
        byteCount = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        inValid = 1'b1; inKeep = 2'b11; inLast = 1'b0; inData = 16'h1234;
        @(posedge clk); #1;
        inData = 16'h5678;
        @(posedge clk); #1;
        inValid = 1'b0;
        nChecks++;
        if ({busy, mValid} !== 2'b11) begin
            nFail++;
            $display("FAIL pre_reset got busy %b valid %b want 1 1", busy, mValid);
        end
        rstN = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({inReady, mValid, mData, mKeep, mLast, busy, done, lenErr, recvBytes} !== 58'd0) begin
            nFail++;
            $display("FAIL midreset_outputs got %h want 0", {inReady, mValid, mData, mKeep, mLast, busy, done, lenErr, recvBytes});
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        readyMode = 1;
        bData = '{16'hBEEF};
        bKeep = '{2'b11};
        bLast = '{1'b1};
        run_xfer(2);
        nChecks++;
        if (gotData.size() != 1) begin
            nFail++;
            $display("FAIL after_reset_words got %0d want 1", gotData.size());
        end else if ({gotData[0], gotKeep[0], gotLast[0]} !== {32'h0000BEEF, 4'b0011, 1'b1}) begin
            nFail++;
            $display("FAIL after_reset_word got %h/%b/%b want 0000beef/0011/1", gotData[0], gotKeep[0], gotLast[0]);
        end
        nChecks++;
        if ({lenErr, recvBytes} !== {1'b0, 16'd2} || doneCount != 1) begin
            nFail++;
            $display("FAIL after_reset_status got err %b recv %0d done %0d want err 0 recv 2 done 1", lenErr, recvBytes, doneCount);
        end
    endtask

    task automatic test_random;
        gapMode = 1;
        readyMode = 2;
        for (int t = 0; t < 40; t++) begin
            int expLen;
            int nb;
            expLen = $urandom_range(1, 20);
            nb = $urandom_range(1, 14);
            bData.delete();
            bKeep.delete();
            bLast.delete();
            for (int i = 0; i < nb; i++) begin
                int r;
                logic [1:0] k;
                r = $urandom_range(0, 9);
                k = (r < 7) ? 2'b11 : (r < 9) ? 2'b00 : 2'b01;
                if (i == nb - 1 && k == 2'b00) k = 2'b11;
                bData.push_back(16'($urandom));
                bKeep.push_back(k);
                bLast.push_back(i == nb - 1);
            end
            build_model(expLen);
            run_xfer(expLen);
            nChecks++;
            if (gotData.size() != expData.size()) begin
                nFail++;
                $display("FAIL rand%0d_words got %0d want %0d", t, gotData.size(), expData.size());
            end else begin
                foreach (expData[i]) begin
                    nChecks++;
                    if ({gotData[i], gotKeep[i], gotLast[i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                        nFail++;
                        $display("FAIL rand%0d_word%0d got %h/%b/%b want %h/%b/%b", t, i, gotData[i], gotKeep[i], gotLast[i], expData[i], expKeep[i], expLast[i]);
                    end
                end
            end
            nChecks++;
            if (lenErr !== expErr || recvBytes !== 16'(expRecv) || doneCount != 1) begin
                nFail++;
                $display("FAIL rand%0d_status got err %b recv %0d done %0d want err %b recv %0d done 1", t, lenErr, recvBytes, doneCount, expErr, expRecv);
            end
        end
        gapMode = 0;
        readyMode = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

`ifdef NFC_PACKER_CHECKSUM_EN
    task automatic test_checksum;
        bData = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        bKeep = '{2'b11, 2'b11, 2'b11, 2'b11};
        bLast = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_xfer(8);
        nChecks++;
        if (checksum !== 32'h04040404) begin
            nFail++;
            $display("FAIL checksum got %h want 04040404", checksum);
        end
    endtask
`endif

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_overlength();
        test_backpressure();
        test_start_busy_and_reset();
        test_random();
`ifdef NFC_PACKER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/nfc_read_stream_packer.md
Name: nfc_read_stream_packer

Overview:
- Downstream consumer of the physical-input read buffer stream (16-bit Valid/Ready/Data/Keep/Last).
- Packs NAND read half-words into 32-bit little-endian words for the DMA/data-path side.
- Enforces the expected transfer length and flags mismatches.
- Sits between the physical input stage and the read DMA; single system clock domain.

Parameters:
- MAX_LEN_W, 16, width of the byte-count request and counters (max transfer 2^16-1 bytes).

Ports:
- iSystemClock  in  1  system clock
- iModuleReset_n  in  1  asynchronous active-low reset
- iStart  in  1  one-cycle pulse; latches iByteCount and starts a transfer; ignored unless idle
- iByteCount  in  MAX_LEN_W  expected bytes for this transfer; must be 1 or more
- iPI_Buff_Valid  in  1  upstream beat valid
- iPI_Buff_Data  in  16  upstream data; byte0 = [7:0] (first on bus)
- iPI_Buff_Keep  in  2  byte enables; legal values are 11, 01, 00
- iPI_Buff_Last  in  1  final upstream beat
- oPI_Buff_Ready  out  1  upstream accept
- oM_Valid  out  1  packed word valid
- oM_Data  out  32  packed word; byte0 = [7:0]
- oM_Keep  out  4  byte enables of the packed word
- oM_Last  out  1  final word of the transfer
- iM_Ready  in  1  downstream accept
- oBusy  out  1  a transfer is in progress
- oDone  out  1  one-cycle pulse when the transfer ends (last word accepted or drain finished)
- oLengthError  out  1  sticky mismatch flag; cleared by iStart
- oRecvBytes  out  MAX_LEN_W  bytes accepted in the current or last transfer

Behaviour:
- Reset: all outputs 0. State IDLE, hold register empty, counters 0.
- FSM states: IDLE, COLLECT, FLUSH, DRAIN, DONE.
- IDLE, on iStart: latch the length, clear oRecvBytes and oLengthError, go to COLLECT.
- oPI_Buff_Ready is 1 only in COLLECT and DRAIN. In COLLECT it also requires (!oM_Valid || iM_Ready).
- Beat accept is Valid && Ready. On each accepted beat, oRecvBytes increases by popcount(Keep), saturating at all-ones.
- Keep 00: beat consumed, no bytes packed.
- Packing uses a hold register (half-word plus a flag).
  - If the hold register is empty and the beat has Keep=11, store the beat.
  - If the hold register is full, load the output register with data {beat, hold}, keep 1111, and clear the hold register.
  - Latency: oM_Valid rises one cycle after the completing half-word is accepted.
- Keep 01 is legal only together with Last, or on the beat that reaches the expected length. Anywhere else: set oLengthError and pack the byte as if it were a full half-word.
- Termination in COLLECT, when an accepted beat has Last or brings oRecvBytes to at least the expected length:
  - If the hold register has content, emit a partial word with keep 0001, 0011 or 0111 as the byte count requires.
  - The emitted word carries oM_Last=1. Go to FLUSH.
- Length rules:
  - Last arriving with oRecvBytes != expected: set oLengthError.
  - Expected length reached without Last: set oLengthError, emit the last word, then go to DRAIN.
- DRAIN: Ready=1; discard beats until Last is accepted, then go to DONE. Discarded bytes are still counted, saturating.
- FLUSH: wait until the oM_Last word is accepted, then go to DONE.
- DONE: pulse oDone for 1 cycle, go to IDLE.
- Output register holds oM_Data, oM_Keep and oM_Last stable while oM_Valid && !iM_Ready.
- oBusy = (state != IDLE).
- iStart while busy: ignored, no side effects.
- Reset asserted mid-transfer: immediate return to IDLE and all state cleared. Any word not yet accepted is lost.

Optional Feature:
- Macro: NFC_PACKER_CHECKSUM_EN.
- Defined:
  - Extra output oChecksum, 32 bits: XOR of all accepted output words, with unkept bytes masked to 0.
  - Cleared by iStart; valid in the oDone cycle and held until the next iStart.
- Undefined: the port and logic are absent. All other behaviour is identical.

Decomposition:
- Package nfc_pkg:
  - FSM state enum (IDLE/COLLECT/FLUSH/DRAIN/DONE).
  - KEEP_FULL16=2'b11 and KEEP_LOW16=2'b01.
  - Function keep_from_bytes(n) returning a 4-bit mask.
- One sub-module: nfc_stream_out_reg, the 32-bit output register with valid/ready hold semantics.
- Packing and FSM stay in the top level.

Test Plan:
- Expected length 8; 4 beats of Keep=11 (0x0100, 0x0302, 0x0504, 0x0706), Last on beat 4 → 2 words 0x03020100 and 0x07060504, keep 1111, Last on word 2, no error, oRecvBytes=8.
- Expected length 5; beats 0x1100, 0x3322, then 0x0044 with Keep=01 and Last → words 0x33221100, then 0x00000044 with keep 0001 and Last; no error.
- Expected length 4; 3 beats of Keep=11 with Last on beat 3 → Last word emitted after 2 beats; DRAIN consumes beat 3; oLengthError=1; oRecvBytes=6; oDone pulses once.
- Expected length 8; iM_Ready held 0 for 10 cycles mid-transfer → oPI_Buff_Ready deasserts; output word stable; no data lost or duplicated after release.
- iStart pulsed while busy → ignored. Reset asserted in COLLECT → all outputs 0 next edge; a following iStart with expected length 2 and 1 beat completes normally.
- With NFC_PACKER_CHECKSUM_EN defined, repeat scenario 1 → oChecksum = 0x03020100 ^ 0x07060504 = 0x04040404.
